imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Instruction-side boot stage that sits directly upstream of the single-cycle core. After reset it accepts a program as a byte stream over a valid/ready handshake, packs the bytes into a word-addressed instruction RAM, and then asserts `I_ready`. From that point it serves `IR` combinationally from the core's registered `IR_addr`. The core holds its PC at 0 while `I_ready` is low, so this block sequences boot versus run for the whole processor.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit instruction words in the RAM. Must be a power of two.
- `AW`, default 8: word-index width; must equal log2(`DEPTH`).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `s_valid` in 1: loader byte valid.
- `s_ready` out 1: loader byte ready.
- `s_data` in 8: program byte, in file order (instruction byte 0 first).
- `s_last` in 1: marks the final byte of the program. Qualified by `s_valid && s_ready`.
- `IR_addr` in 32: byte address from the core.
- `IR` out 32: instruction word in the core's stored byte order.
- `I_ready` out 1: program loaded; core may run.
- `load_err` out 1: sticky load error.
- `word_count` out AW+1: number of words written.

## Operation
- States:
  - IDLE: reset state, no byte yet.
  - LOAD: at least one byte accepted.
  - RUN: program complete.
  - ERR: load failed.
- A byte is accepted on a rising edge with `s_valid && s_ready`. `s_ready = 1` in IDLE and LOAD, and 0 in RUN and ERR.
- Byte packing:
  - A 2-bit byte counter `bc` selects the lane. Byte with `bc = k` goes to word bits [31-8k : 24-8k], so the word is {b0, b1, b2, b3}.
  - On the edge accepting the byte with `bc = 3`, the assembled word is written to `ram[word_count]`, `word_count` increments, and `bc` wraps to 0.
- IDLE → LOAD on the first accepted byte without `s_last`.
- LOAD/IDLE → RUN on an accepted byte with `s_last = 1` and `bc = 3`. The final word is written on the same edge.
- → ERR on either of these conditions:
  - `s_last` accepted with `bc ≠ 3` (partial word). That partial word is discarded.
  - A byte accepted with `bc = 0` while `word_count = DEPTH` (overflow).
- RUN and ERR are terminal; only `rst` leaves them. Further `s_valid` is ignored (not accepted).
- `I_ready = (state == RUN)`, driven from the state register with no combinational path from the stream inputs.
- `load_err = (state == ERR)`.
- Instruction read:
  - Word index `idx = IR_addr[AW+1:2]`. `IR_addr[1:0]` is ignored.
  - If `IR_addr[31:AW+2] ≠ 0` or `idx ≥ word_count`, then `IR = 32'h1300_0000` (NOP, addi x0,x0,0, in stored byte order).
  - Otherwise `IR = ram[idx]`.
  - `IR` is driven in every state. Before RUN it reflects only the words written so far.
- RAM has no reset; `word_count` masking guarantees unwritten words are never returned.

## Timing
- Reset values: state IDLE, `bc` 0, `word_count` 0, `s_ready` 1 (first cycle after reset), `I_ready` 0, `load_err` 0.
- `IR` after reset is NOP for every address.
- Throughput: one byte per cycle; `s_ready` stays high through LOAD.
- Write latency: a word is visible on `IR` in the cycle after the edge accepting its 4th byte (`word_count` and RAM update on the same edge).
- `I_ready` rises in the cycle after the edge accepting the final byte. `s_ready` falls in that same cycle.
- Read latency: zero. `IR` is a combinational function of `IR_addr`, `ram` and `word_count`, because the core registers `IR_addr` and decodes `IR` in the same cycle.
- Reset mid-load or in RUN/ERR: at the next edge with `rst = 0`, return to IDLE with `bc = 0`, `word_count = 0`, `I_ready = 0`. Any partially assembled word is lost.
- Simultaneous `s_last` and overflow: overflow takes priority; go to ERR and perform no write.
- An exactly full load (`DEPTH` words, `s_last` on the final byte) is legal and goes to RUN.

## Test plan
- Load 8 bytes 13,05,10,00,93,05,20,00 with `s_last` on the 8th. Require:
  - `word_count = 2` and `I_ready = 1` in the cycle after byte 8.
  - `IR_addr = 0` gives `IR = 32'h1305_1000`; `IR_addr = 4` gives `32'h9305_2000`; `IR_addr = 8` gives `32'h1300_0000`.
- Assert `s_last` on the 6th byte. Require `load_err = 1`, `I_ready = 0`, `s_ready = 0`, `word_count = 1`; `IR_addr = 4` returns NOP.
- With `DEPTH = 4`, stream 17 bytes. Require ERR on the 17th byte and `word_count = 4`; `IR` for indices 0–3 holds the loaded words.
- Assert `rst = 0` after 3 bytes, then reload 4 bytes with `s_last`. Require `ram[0]` holds only the new word and `I_ready` rises.
- In RUN, drive `IR_addr = 32'h0000_0003` and `32'h0001_0000`. Require the word at index 0 for the first and NOP for the second; `s_valid` pulses are not accepted and `word_count` is unchanged.
- Toggle `s_valid` randomly during load. Require bytes packed only on handshake cycles, with the final `IR` contents matching the golden image.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Purpose : boot-time byte-stream loader that fills the instruction RAM, then serves IR to the core.
// Latency : a word appears on IR the cycle after its 4th byte is accepted; IR reads are combinational.
// Backpressure: s_ready is high in IDLE/LOAD (one byte per cycle) and low once RUN or ERR is reached.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   s_valid/s_ready  byte stream handshake; s_data is the byte, s_last marks the final byte
//   IR_addr, IR      byte address from the core, instruction word returned (NOP when unloaded)
//   I_ready          program fully loaded, core may run
//   load_err         sticky load failure (partial final word or overflow)
//   word_count       number of words written so far
module imem_boot_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    input  logic [31:0]   IR_addr,
    output logic [31:0]   IR,
    output logic          I_ready,
    output logic          load_err,
    output logic [AW:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h1300_0000;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  bc;
    logic [23:0] pend;
    logic [AW:0] wc;
    logic [31:0] ram [DEPTH];

    logic        accept;
    logic        overflow;
    logic        wr_en;
    logic [31:0] wr_word;

    assign s_ready    = (state == IDLE) || (state == LOAD);
    assign I_ready    = (state == RUN);
    assign load_err   = (state == ERR);
    assign word_count = wc;

    assign accept   = s_valid && s_ready;
    // A new word starting while the RAM is already full is the only overflow case;
    // at bc = 3 the count is necessarily below DEPTH, so overflow and write never coincide.
    assign overflow = accept && (bc == 2'd0) && (wc == FULL);
    assign wr_en    = accept && (bc == 2'd3);
    // Earlier bytes sit in pend in arrival order, so the first byte lands in bits [31:24].
    assign wr_word  = {pend, s_data};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (overflow) begin
                        state_nxt = ERR;
                    end else if (s_last) begin
                        state_nxt = (bc == 2'd3) ? RUN : ERR;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            RUN:     state_nxt = RUN;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            bc    <= 2'd0;
            pend  <= 24'd0;
            wc    <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !overflow) begin
                bc   <= bc + 2'd1;
                pend <= {pend[15:0], s_data};
                if (bc == 2'd3) begin
                    wc <= wc + 1'b1;
                end
            end
        end
    end

    // RAM is not reset: word_count masking keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            ram[wc[AW-1:0]] <= wr_word;
        end
    end

    logic [AW-1:0] rd_idx;
    logic          rd_hit;
    logic          unused_addr_lsb;

    assign rd_idx          = IR_addr[AW+1:2];
    assign rd_hit          = (IR_addr[31:AW+2] == '0) && ({1'b0, rd_idx} < wc);
    assign IR              = rd_hit ? ram[rd_idx] : NOP;
    assign unused_addr_lsb = ^IR_addr[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam logic [31:0] NOP = 32'h1300_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       sv;
    logic [1:0]       sl;
    logic [1:0][7:0]  sd;
    logic [1:0][31:0] addr;
    wire  [1:0]       srdy;
    wire  [1:0]       irdy;
    wire  [1:0]       lerr;
    wire  [1:0][31:0] ir;
    wire  [8:0]       wc0;
    wire  [2:0]       wc1;

    imem_boot_loader #(.DEPTH(256), .AW(8)) dut0 (
        .clk(clk), .rst(rst),
        .s_valid(sv[0]), .s_ready(srdy[0]), .s_data(sd[0]), .s_last(sl[0]),
        .IR_addr(addr[0]), .IR(ir[0]), .I_ready(irdy[0]), .load_err(lerr[0]),
        .word_count(wc0)
    );

    imem_boot_loader #(.DEPTH(4), .AW(2)) dut1 (
        .clk(clk), .rst(rst),
        .s_valid(sv[1]), .s_ready(srdy[1]), .s_data(sd[1]), .s_last(sl[1]),
        .IR_addr(addr[1]), .IR(ir[1]), .I_ready(irdy[1]), .load_err(lerr[1]),
        .word_count(wc1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, want %h", nm, i, got, exp);
    endtask

    // Behavioural model: a list of completed words, the bytes of the word in progress,
    // and two flags for "program complete" and "load failed".
    int          dep [2] = '{256, 4};
    int          aw  [2] = '{8, 2};
    logic [31:0] mmem [2][256];
    int          mwc [2];
    int          mpn [2];
    logic [7:0]  mpb [2][3];
    bit          mrun [2];
    bit          merr [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                mwc[i]  <= 0;
                mpn[i]  <= 0;
                mrun[i] <= 1'b0;
                merr[i] <= 1'b0;
            end else if (sv[i] && !mrun[i] && !merr[i]) begin
                if (mpn[i] == 0 && mwc[i] == dep[i]) begin
                    merr[i] <= 1'b1;
                end else if (mpn[i] == 3) begin
                    mmem[i][mwc[i]] <= {mpb[i][0], mpb[i][1], mpb[i][2], sd[i]};
                    mwc[i]          <= mwc[i] + 1;
                    mpn[i]          <= 0;
                    if (sl[i]) mrun[i] <= 1'b1;
                end else begin
                    mpb[i][mpn[i]] <= sd[i];
                    mpn[i]         <= mpn[i] + 1;
                    if (sl[i]) merr[i] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] mir(int i, logic [31:0] a);
        int idx;
        if ((a >> (aw[i] + 2)) != 0) return NOP;
        idx = int'(a >> 2);
        if (idx < mwc[i]) return mmem[i][idx];
        return NOP;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("s_ready",    i, 32'(srdy[i]), 32'(!(mrun[i] || merr[i])));
                chk("I_ready",    i, 32'(irdy[i]), 32'(mrun[i]));
                chk("load_err",   i, 32'(lerr[i]), 32'(merr[i]));
                chk("word_count", i, (i == 0) ? 32'(wc0) : 32'(wc1), 32'(mwc[i]));
                chk("IR",         i, ir[i], mir(i, addr[i]));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send(int i, logic [7:0] d, bit l);
        sv[i] = 1'b1;
        sd[i] = d;
        sl[i] = l;
        tick();
        sv[i] = 1'b0;
        sl[i] = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic set_addr(int i, logic [31:0] a);
        addr[i] = a;
        #1;
    endtask

    task automatic sweep(int i, int nw);
        for (int w = 0; w < nw; w++) begin
            addr[i] = 32'(w * 4);
            tick();
        end
    endtask

    logic [7:0] prog1 [8]  = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    logic [7:0] img   [12] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00,
                               8'hB7, 8'h12, 8'h34, 8'h56};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        rst  = 1'b0;
        sv   = '0;
        sl   = '0;
        sd   = '0;
        addr = '0;
        tick();
        tick();
        rst    = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_word_count", 0, 32'(wc0), 32'd0);
        chk("rst_s_ready",    0, 32'(srdy[0]), 32'd1);
        chk("rst_I_ready",    0, 32'(irdy[0]), 32'd0);
        chk("rst_load_err",   0, 32'(lerr[0]), 32'd0);
        chk("rst_IR",         0, ir[0], NOP);

        // Two-word program
        for (int b = 0; b < 8; b++) send(0, prog1[b], b == 7);
        chk("p1_word_count", 0, 32'(wc0), 32'd2);
        chk("p1_I_ready",    0, 32'(irdy[0]), 32'd1);
        chk("p1_s_ready",    0, 32'(srdy[0]), 32'd0);
        set_addr(0, 32'd0); chk("p1_IR0", 0, ir[0], 32'h1305_1000);
        set_addr(0, 32'd4); chk("p1_IR4", 0, ir[0], 32'h9305_2000);
        set_addr(0, 32'd8); chk("p1_IR8", 0, ir[0], NOP);

        // RUN: low address bits ignored, high bits force NOP, stream ignored
        set_addr(0, 32'h0000_0003); chk("run_IR3",     0, ir[0], 32'h1305_1000);
        set_addr(0, 32'h0001_0000); chk("run_IR_high", 0, ir[0], NOP);
        sv[0] = 1'b1;
        sd[0] = 8'hFF;
        for (int c = 0; c < 3; c++) tick();
        sv[0] = 1'b0;
        chk("run_word_count", 0, 32'(wc0), 32'd2);
        set_addr(0, 32'd8); chk("run_IR8", 0, ir[0], NOP);

        // s_last on a partial word
        do_reset();
        for (int b = 0; b < 6; b++) send(0, prog1[b], b == 5);
        chk("part_load_err",   0, 32'(lerr[0]), 32'd1);
        chk("part_I_ready",    0, 32'(irdy[0]), 32'd0);
        chk("part_s_ready",    0, 32'(srdy[0]), 32'd0);
        chk("part_word_count", 0, 32'(wc0), 32'd1);
        set_addr(0, 32'd4); chk("part_IR4", 0, ir[0], NOP);
        set_addr(0, 32'd0); chk("part_IR0", 0, ir[0], 32'h1305_1000);

        // DEPTH=4 overflow on the 17th byte, which also carries s_last
        for (int b = 0; b < 17; b++) send(1, 8'(b * 7 + 1), b == 16);
        chk("ovf_load_err",   1, 32'(lerr[1]), 32'd1);
        chk("ovf_word_count", 1, 32'(wc1), 32'd4);
        sweep(1, 6);
        set_addr(1, 32'd0);  chk("ovf_IR0",  1, ir[1], 32'h0108_0F16);
        set_addr(1, 32'd12); chk("ovf_IR12", 1, ir[1], 32'h555C_636A);
        set_addr(1, 32'd16); chk("ovf_IR16", 1, ir[1], NOP);

        // DEPTH=4 exactly full load is legal
        do_reset();
        for (int b = 0; b < 16; b++) send(1, 8'(b * 7 + 1), b == 15);
        chk("full_I_ready",    1, 32'(irdy[1]), 32'd1);
        chk("full_load_err",   1, 32'(lerr[1]), 32'd0);
        chk("full_word_count", 1, 32'(wc1), 32'd4);
        sweep(1, 5);

        // Reset mid-load discards the partial word
        do_reset();
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hCC, 1'b0);
        do_reset();
        send(0, 8'h37, 1'b0);
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        set_addr(0, 32'd0);
        chk("rel_IR0",        0, ir[0], 32'h3711_2233);
        chk("rel_I_ready",    0, 32'(irdy[0]), 32'd1);
        chk("rel_word_count", 0, 32'(wc0), 32'd1);

        // Random valid gaps, junk data on idle cycles
        do_reset();
        k     = 0;
        guard = 0;
        while (k < 12 && guard < 500) begin
            sv[0] = 1'($urandom_range(0, 1));
            sd[0] = sv[0] ? img[k] : 8'($urandom);
            sl[0] = sv[0] && (k == 11);
            tick();
            if (sv[0]) k++;
            guard++;
        end
        sv[0] = 1'b0;
        sl[0] = 1'b0;
        chk("rand_bytes_sent",  0, 32'(k), 32'd12);
        chk("rand_I_ready",     0, 32'(irdy[0]), 32'd1);
        chk("rand_word_count",  0, 32'(wc0), 32'd3);
        set_addr(0, 32'd0);  chk("rand_IR0",  0, ir[0], 32'h9300_1000);
        set_addr(0, 32'd4);  chk("rand_IR4",  0, ir[0], 32'h1301_2000);
        set_addr(0, 32'd8);  chk("rand_IR8",  0, ir[0], 32'hB712_3456);
        set_addr(0, 32'd12); chk("rand_IR12", 0, ir[0], NOP);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
